bank_pingpong_ctrl: RTL and testbench

//  Ping-pong scheduler for the two 16-bit data SRAM banks in the receiver.
//  - Streams incoming samples into the "fill" bank.
//  - Hands the other bank to the DSP for processing.
//  - Swaps roles when a frame is complete and the DSP reports done.
//  - Owns both banks' write ports: fill writes plus DSP writes are routed to the correct bank.

---
 rtl/bank_pingpong_ctrl_pkg.sv | 11 +
 rtl/bank_pingpong_ctrl_if.sv | 37 +++
 rtl/bank_pingpong_ctrl_bank_write_mux.sv | 41 ++++
 rtl/bank_pingpong_ctrl.sv | 137 +++++++++++++
 tb/tb_bank_pingpong_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bank_pingpong_ctrl_pkg.sv
// Shared types for the receiver ping-pong bank scheduler.
package receiver_pkg;

  typedef enum logic {FILL = 1'b0, WAIT_DSP = 1'b1} pp_state_t;

  typedef logic bank_sel_t;

  localparam bank_sel_t BANK_I  = 1'b0;
  localparam bank_sel_t BANK_II = 1'b1;

endpackage

// File: rtl/bank_pingpong_ctrl_if.sv
// Sample stream, DSP handshake and bank write-port bundle for bank_pingpong_ctrl.
interface bank_pingpong_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dsp_start;
  logic              dsp_bank;
  logic              dsp_done;
  logic [ADDR_W-1:0] dsp_waddr;
  logic [DATA_W-1:0] dsp_wdata;
  logic              dsp_wen;
  logic [ADDR_W-1:0] write_addr_1;
  logic [DATA_W-1:0] write_data_1;
  logic              write_en_1;
  logic [ADDR_W-1:0] write_addr_2;
  logic [DATA_W-1:0] write_data_2;
  logic              write_en_2;
  logic [15:0]       overrun_cnt;

  modport slave (
    input  in_valid, in_data, dsp_done, dsp_waddr, dsp_wdata, dsp_wen,
    output in_ready, dsp_start, dsp_bank,
           write_addr_1, write_data_1, write_en_1,
           write_addr_2, write_data_2, write_en_2, overrun_cnt
  );

  modport master (
    output in_valid, in_data, dsp_done, dsp_waddr, dsp_wdata, dsp_wen,
    input  in_ready, dsp_start, dsp_bank,
           write_addr_1, write_data_1, write_en_1,
           write_addr_2, write_data_2, write_en_2, overrun_cnt
  );

endinterface

// File: rtl/bank_pingpong_ctrl_bank_write_mux.sv
// Combinational routing of the registered fill write and the DSP write onto bank I/II.
module bank_write_mux
  import receiver_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              fill_en,
  input  bank_sel_t         fill_bank,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  bank_sel_t         dsp_bank,
  input  logic              dsp_en,
  input  logic [ADDR_W-1:0] dsp_addr,
  input  logic [DATA_W-1:0] dsp_data,
  output logic [ADDR_W-1:0] addr_1,
  output logic [DATA_W-1:0] data_1,
  output logic              en_1,
  output logic [ADDR_W-1:0] addr_2,
  output logic [DATA_W-1:0] data_2,
  output logic              en_2
);

  logic fill_hit_1, fill_hit_2, dsp_hit_1, dsp_hit_2;

  // The final fill write of a frame lands one cycle after the swap, in the bank the DSP
  // now owns; it takes the port so a bank never has two writers in one cycle.
  always_comb begin
    fill_hit_1 = fill_en && (fill_bank == BANK_I);
    fill_hit_2 = fill_en && (fill_bank == BANK_II);
    dsp_hit_1  = dsp_en && (dsp_bank == BANK_I) && !fill_hit_1;
    dsp_hit_2  = dsp_en && (dsp_bank == BANK_II) && !fill_hit_2;
    en_1       = fill_hit_1 || dsp_hit_1;
    en_2       = fill_hit_2 || dsp_hit_2;
    addr_1     = dsp_hit_1 ? dsp_addr : fill_addr;
    data_1     = dsp_hit_1 ? dsp_data : fill_data;
    addr_2     = dsp_hit_2 ? dsp_addr : fill_addr;
    data_2     = dsp_hit_2 ? dsp_data : fill_data;
  end

endmodule

// File: rtl/bank_pingpong_ctrl.sv
// Ping-pong scheduler for two sample banks shared between the input stream and the DSP.
// Optional PINGPONG_OVERRUN_DROP_EN: keep accepting while waiting on the DSP, drop and count.
//
//   state    | meaning
//   FILL     | streaming samples into fill_bank, in_ready high
//   WAIT_DSP | frame complete, DSP still holds the other bank; waiting for dsp_done
module bank_pingpong_ctrl
  import receiver_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  bank_pingpong_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  pp_state_t         state_q, state_d;
  bank_sel_t         fill_bank_q, fill_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              dsp_busy_q, dsp_busy_d;
  logic              dsp_start_q, dsp_start_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  bank_sel_t         wr_bank_q, wr_bank_d;
  logic [15:0]       ovr_q, ovr_d;
  logic              accept, last;

  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    wr_ptr_d    = wr_ptr_q;
    dsp_busy_d  = dsp_busy_q;
    dsp_start_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_bank_d   = wr_bank_q;
    ovr_d       = ovr_q;
    accept      = bus.in_valid && in_ready_q;
    last        = (wr_ptr_q == LAST_PTR);
    case (state_q)
      FILL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_data_d = bus.in_data;
          wr_bank_d = fill_bank_q;
          wr_ptr_d  = last ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (accept && last) begin
          if (!dsp_busy_q || bus.dsp_done) begin
            fill_bank_d = ~fill_bank_q;
            dsp_busy_d  = 1'b1;
            dsp_start_d = 1'b1;
          end else begin
            state_d = WAIT_DSP;
          end
        end else if (bus.dsp_done) begin
          dsp_busy_d = 1'b0;
        end
      end
      WAIT_DSP: begin
        if (bus.dsp_done) begin
          fill_bank_d = ~fill_bank_q;
          dsp_start_d = 1'b1;
          state_d     = FILL;
        end
`ifdef PINGPONG_OVERRUN_DROP_EN
        if (accept && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
`endif
      end
      default: state_d = FILL;
    endcase
`ifdef PINGPONG_OVERRUN_DROP_EN
    in_ready_d = 1'b1;
`else
    in_ready_d = (state_d == FILL);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fill_bank_q <= BANK_I;
      wr_ptr_q    <= '0;
      dsp_busy_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= BANK_I;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      dsp_busy_q  <= dsp_busy_d;
      dsp_start_q <= dsp_start_d;
      in_ready_q  <= in_ready_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.dsp_start   = dsp_start_q;
  assign bus.dsp_bank    = ~fill_bank_q;
  assign bus.overrun_cnt = ovr_q;

  bank_write_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .fill_en   (wr_en_q),
    .fill_bank (wr_bank_q),
    .fill_addr (wr_addr_q),
    .fill_data (wr_data_q),
    .dsp_bank  (~fill_bank_q),
    .dsp_en    (bus.dsp_wen && dsp_busy_q),
    .dsp_addr  (bus.dsp_waddr),
    .dsp_data  (bus.dsp_wdata),
    .addr_1    (bus.write_addr_1),
    .data_1    (bus.write_data_1),
    .en_1      (bus.write_en_1),
    .addr_2    (bus.write_addr_2),
    .data_2    (bus.write_data_2),
    .en_2      (bus.write_en_2)
  );

endmodule

// File: tb/tb_bank_pingpong_ctrl.sv
// Directed plus random bench for bank_pingpong_ctrl against a frame-level reference model.
module tb_bank_pingpong_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bank_pingpong_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bank_pingpong_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit drop_mode = 1'b0;

  // frame-level reference state
  bit          m_fill, m_busy, m_stall, m_start;
  int          m_ptr;
  int unsigned m_ovr;
  bit          p_vld, p_bank;
  int          p_addr;
  logic [DW-1:0] p_data;
  logic [DW-1:0] cur_frame [FL];
  logic [DW-1:0] exp_frame [2][FL];
  logic [DW-1:0] shadow    [2][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_fill = 0; m_busy = 0; m_stall = 0; m_start = 0;
    m_ptr = 0; m_ovr = 0; p_vld = 0;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit done, input bit dwen,
                      input logic [AW-1:0] daddr, input logic [DW-1:0] ddata);
    bit exp_rdy, acc, e_en, g_en;
    int e_addr, g_addr;
    logic [DW-1:0] e_data, g_data;
    @(negedge clk);
    bus.in_valid = v;  bus.in_data = d;    bus.dsp_done = done;
    bus.dsp_wen = dwen; bus.dsp_waddr = daddr; bus.dsp_wdata = ddata;
    #1;
    exp_rdy = !m_stall || drop_mode;
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("dsp_start", bus.dsp_start, m_start);
    chk("dsp_bank", bus.dsp_bank, !m_fill);
    chk("overrun_cnt", bus.overrun_cnt, m_ovr);
    for (int b = 0; b < 2; b++) begin
      e_en = 0; e_addr = 0; e_data = '0;
      if (p_vld && (p_bank == b)) begin
        e_en = 1; e_addr = p_addr; e_data = p_data;
      end else if (dwen && m_busy && (b == int'(!m_fill))) begin
        e_en = 1; e_addr = int'(daddr); e_data = ddata;
      end
      g_en   = (b == 0) ? bus.write_en_1 : bus.write_en_2;
      g_addr = int'((b == 0) ? bus.write_addr_1 : bus.write_addr_2);
      g_data = (b == 0) ? bus.write_data_1 : bus.write_data_2;
      chk(b == 0 ? "write_en_1" : "write_en_2", g_en, e_en);
      if (e_en) begin
        chk(b == 0 ? "write_addr_1" : "write_addr_2", g_addr, e_addr);
        chk(b == 0 ? "write_data_1" : "write_data_2", g_data, e_data);
      end
    end
    if (bus.write_en_1) shadow[0][bus.write_addr_1] = bus.write_data_1;
    if (bus.write_en_2) shadow[1][bus.write_addr_2] = bus.write_data_2;
    // a started frame must already sit complete in the bank handed to the DSP
    if (m_start)
      for (int i = 0; i < FL; i++)
        chk("frame_data", shadow[!m_fill][i], exp_frame[!m_fill][i]);
    acc = v && exp_rdy;
    m_start = 0;
    p_vld = 0;
    if (m_stall) begin
      if (acc && m_ovr != 32'hFFFF) m_ovr++;
      if (done) begin
        m_fill = !m_fill; m_start = 1; m_stall = 0;
      end
    end else begin
      if (acc) begin
        cur_frame[m_ptr] = d;
        p_vld = 1; p_bank = m_fill; p_addr = m_ptr; p_data = d;
        m_ptr++;
      end
      if (acc && m_ptr == FL) begin
        m_ptr = 0;
        for (int i = 0; i < FL; i++) exp_frame[m_fill][i] = cur_frame[i];
        if (!m_busy || done) begin
          m_fill = !m_fill; m_busy = 1; m_start = 1;
        end else begin
          m_stall = 1;
        end
      end else if (done) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, '0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.in_valid = 0; bus.dsp_done = 0; bus.dsp_wen = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_dsp_start", bus.dsp_start, 0);
    chk("rst_dsp_bank", bus.dsp_bank, 1);
    chk("rst_write_en_1", bus.write_en_1, 0);
    chk("rst_write_en_2", bus.write_en_2, 0);
    chk("rst_overrun", bus.overrun_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
`ifdef PINGPONG_OVERRUN_DROP_EN
    drop_mode = 1'b1;
`endif
    bus.in_valid = 0; bus.in_data = '0; bus.dsp_done = 0;
    bus.dsp_wen = 0; bus.dsp_waddr = '0; bus.dsp_wdata = '0;
    async_reset();

    // frame 1 into bank I, DSP idle
    for (int i = 0; i < FL; i++) step(1, DW'(16'hA0 + i), 0, 0, '0, '0);
    idle();
    chk("f1_start", bus.dsp_start, 1);
    chk("f1_dsp_bank", bus.dsp_bank, 0);
    chk("f1_last_addr", bus.write_addr_1, 3);

    // frame 2 into bank II while DSP busy: stall, optional drops
    for (int i = 0; i < FL; i++) step(1, DW'(16'hB0 + i), 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step(1, DW'(16'hBE), 0, 0, '0, '0);
    idle();
    chk("stall_overrun", bus.overrun_cnt, drop_mode ? 3 : 0);
    chk("stall_en_1", bus.write_en_1, 0);
    chk("stall_en_2", bus.write_en_2, 0);
    step(0, '0, 1, 0, '0, '0);
    idle();
    chk("f2_start", bus.dsp_start, 1);
    chk("f2_dsp_bank", bus.dsp_bank, 1);

    // frame 3: dsp_done coincides with the frame-complete accept
    for (int i = 0; i < FL - 1; i++) step(1, DW'(16'hC0 + i), 0, 0, '0, '0);
    step(1, DW'(16'hC3), 1, 0, '0, '0);
    idle();
    chk("f3_no_stall", bus.in_ready, 1);
    chk("f3_dsp_bank", bus.dsp_bank, 0);

    // DSP write to bank I while filling bank II
    step(1, DW'(16'hD0), 0, 1, AW'(5), DW'(16'h55));
    chk("dspw_en_1", bus.write_en_1, 1);
    chk("dspw_addr_1", bus.write_addr_1, 5);
    chk("dspw_en_2", bus.write_en_2, 0);
    step(1, DW'(16'hD1), 0, 0, '0, '0);

    // reset with a partial frame, then restart at bank I addr 0
    async_reset();
    for (int i = 0; i < FL; i++) step(1, DW'(16'hE0 + i), 0, 0, '0, '0);
    idle();
    chk("post_rst_start", bus.dsp_start, 1);
    chk("post_rst_dsp_bank", bus.dsp_bank, 0);

    for (int n = 0; n < 400; n++)
      step(($urandom % 10) < 7, DW'($urandom), ($urandom % 8) == 0, ($urandom % 4) == 0,
           AW'(FL + ($urandom % (256 - FL))), DW'($urandom));
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
